// File: rtl/pll_mode_ctrl.sv
// Programs the rPLL dividers from a 4-entry mode table, resets the PLL and qualifies lock.
// Latency: request accepted at T, new selects and pll_reset=1 at T+1; lock seen 2 cycles after pll_lock.
// Backpressure: mode_req_ready only in RUN/FAIL; requests while busy are dropped, not queued.
module pll_mode_ctrl #(
  parameter logic [17:0] MODE0_SEL     = 18'h0,
  parameter logic [17:0] MODE1_SEL     = 18'h0,
  parameter logic [17:0] MODE2_SEL     = 18'h0,
  parameter logic [17:0] MODE3_SEL     = 18'h0,
  parameter int          RESET_CYCLES  = 16,
  parameter int          LOCK_TIMEOUT  = 65535,
  parameter int          SETTLE_CYCLES = 1024,
  parameter int          MAX_RETRY     = 3
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       mode_req_valid,
  input  logic [1:0] mode_req,
  output logic       mode_req_ready,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic       out_rst_n,
  output logic [1:0] cur_mode,
  output logic       busy,
  output logic       fail
);

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam logic [19:0] RST_LAST    = 20'(RESET_CYCLES - 1);
  localparam logic [19:0] LOCK_LAST   = 20'(LOCK_TIMEOUT);
  localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRY);

  state_t      state;
  state_t      state_nxt;
  logic [19:0] cnt;
  logic [3:0]  retry_cnt;
  logic [3:0]  retry_nxt;
  logic [3:0]  retry_inc;
  logic        lock_s1;
  logic        lock_s;
  logic        accept;
  logic        load_mode;

  function automatic logic [17:0] mode_sel(input logic [1:0] m);
    case (m)
      2'd0:    mode_sel = MODE0_SEL;
      2'd1:    mode_sel = MODE1_SEL;
      2'd2:    mode_sel = MODE2_SEL;
      default: mode_sel = MODE3_SEL;
    endcase
  endfunction

  // ready is registered from the state, so it is only ever high in RUN/FAIL
  assign accept    = mode_req_valid && mode_req_ready;
  assign retry_inc = retry_cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    load_mode = 1'b0;
    case (state)
      RST_HOLD: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = SETTLE;
        end else if (cnt == LOCK_LAST) begin
          retry_nxt = retry_inc;
          if (retry_inc == RETRY_MAX) state_nxt = FAIL;
          else                        state_nxt = RST_HOLD;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          retry_nxt = retry_inc;
          if (retry_inc == RETRY_MAX) state_nxt = FAIL;
          else                        state_nxt = RST_HOLD;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = RUN;
          retry_nxt = 4'd0;
        end
      end
      RUN: begin
        // an accepted request takes priority over a coincident lock loss
        if (accept) begin
          load_mode = 1'b1;
          state_nxt = RST_HOLD;
        end else if (!lock_s) begin
          state_nxt = RST_HOLD;
          retry_nxt = 4'd0;
        end
      end
      FAIL: begin
        if (accept) begin
          load_mode = 1'b1;
          retry_nxt = 4'd0;
          state_nxt = RST_HOLD;
        end
      end
      default: begin
        state_nxt = RST_HOLD;
      end
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= RST_HOLD;
      cnt                    <= 20'd0;
      retry_cnt              <= 4'd0;
      lock_s1                <= 1'b0;
      lock_s                 <= 1'b0;
      pll_reset              <= 1'b1;
      out_rst_n              <= 1'b0;
      busy                   <= 1'b1;
      fail                   <= 1'b0;
      mode_req_ready         <= 1'b0;
      cur_mode               <= 2'd0;
      {idsel, fbdsel, odsel} <= MODE0_SEL;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      lock_s1   <= pll_lock;
      lock_s    <= lock_s1;
      // counter restarts on every state entry and saturates while parked
      if (state_nxt != state) cnt <= 20'd0;
      else if (cnt != '1)     cnt <= cnt + 20'd1;
      pll_reset      <= (state_nxt == RST_HOLD) || (state_nxt == FAIL);
      out_rst_n      <= (state_nxt == RUN);
      busy           <= (state_nxt == RST_HOLD) || (state_nxt == WAIT_LOCK) ||
                        (state_nxt == SETTLE);
      fail           <= (state_nxt == FAIL);
      mode_req_ready <= (state_nxt == RUN) || (state_nxt == FAIL);
      if (load_mode) begin
        cur_mode               <= mode_req;
        {idsel, fbdsel, odsel} <= mode_sel(mode_req);
      end
    end
  end

endmodule

// File: tb/tb_pll_mode_ctrl.sv
// Directed bench for pll_mode_ctrl: mode entries are checked against a scoreboard of requested modes.
module tb_pll_mode_ctrl;

  localparam int RC = 16;
  localparam int LT = 100;
  localparam int SC = 1024;
  localparam int MR = 3;
  localparam logic [17:0] M0 = {6'd1, 6'd20, 6'd4};
  localparam logic [17:0] M1 = {6'd2, 6'd30, 6'd3};
  localparam logic [17:0] M2 = {6'd3, 6'd40, 6'd2};
  localparam logic [17:0] M3 = {6'd4, 6'd50, 6'd1};

  logic       clkin = 1'b0;
  logic       rst_n;
  logic       mode_req_valid;
  logic [1:0] mode_req;
  logic       mode_req_ready;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] idsel;
  logic [5:0] fbdsel;
  logic [5:0] odsel;
  logic       out_rst_n;
  logic [1:0] cur_mode;
  logic       busy;
  logic       fail;

  pll_mode_ctrl #(
    .MODE0_SEL(M0), .MODE1_SEL(M1), .MODE2_SEL(M2), .MODE3_SEL(M3),
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SC), .MAX_RETRY(MR)
  ) dut (
    .clkin(clkin), .rst_n(rst_n),
    .mode_req_valid(mode_req_valid), .mode_req(mode_req), .mode_req_ready(mode_req_ready),
    .pll_lock(pll_lock), .pll_reset(pll_reset),
    .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel),
    .out_rst_n(out_rst_n), .cur_mode(cur_mode), .busy(busy), .fail(fail)
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [17:0] sel;
  } exp_t;
  exp_t sb[$];

  function automatic logic [17:0] exp_sel(input logic [1:0] m);
    case (m)
      2'd0:    exp_sel = M0;
      2'd1:    exp_sel = M1;
      2'd2:    exp_sel = M2;
      default: exp_sel = M3;
    endcase
  endfunction

  function logic sig(input int which);
    case (which)
      0:       sig = pll_reset;
      1:       sig = out_rst_n;
      2:       sig = fail;
      default: sig = mode_req_ready;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // counts cycles while the selected output holds val; the exit itself is a check
  task automatic measure(input string tag, input int which, input logic val,
                         input int budget, output int n);
    n = 0;
    while (sig(which) === val && n < budget) begin
      @(negedge clkin);
      n++;
    end
    check({tag, "_exit"}, {31'd0, sig(which)}, {31'd0, ~val});
  endtask

  task automatic request(input logic [1:0] m);
    mode_req_valid = 1'b1;
    mode_req       = m;
    sb.push_back('{mode: m, sel: exp_sel(m)});
    @(negedge clkin);
    mode_req_valid = 1'b0;
  endtask

  task automatic pop_entry(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_cur_mode"}, {30'd0, cur_mode}, {30'd0, e.mode});
      check({tag, "_sel"}, {14'd0, idsel, fbdsel, odsel}, {14'd0, e.sel});
      check({tag, "_pll_reset"}, {31'd0, pll_reset}, 32'd1);
      check({tag, "_out_rst_n"}, {31'd0, out_rst_n}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_ready"}, {31'd0, mode_req_ready}, 32'd0);
      check({tag, "_fail"}, {31'd0, fail}, 32'd0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_reset"}, {31'd0, pll_reset}, 32'd1);
    check({tag, "_out_rst_n"}, {31'd0, out_rst_n}, 32'd0);
    check({tag, "_cur_mode"}, {30'd0, cur_mode}, 32'd0);
    check({tag, "_sel"}, {14'd0, idsel, fbdsel, odsel}, {14'd0, M0});
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_fail"}, {31'd0, fail}, 32'd0);
    check({tag, "_ready"}, {31'd0, mode_req_ready}, 32'd0);
  endtask

  initial begin
    int n;
    int tot;
    rst_n          = 1'b0;
    pll_lock       = 1'b1;
    mode_req_valid = 1'b0;
    mode_req       = 2'd0;
    repeat (2) @(negedge clkin);
    check_reset_vals("por");

    // reset release with lock tied high
    rst_n = 1'b1;
    measure("por_rst", 0, 1'b1, 200, n);
    check("por_rst_width", n, RC);
    tot = n;
    measure("por_release", 1, 1'b0, 3000, n);
    tot += n;
    check("por_release_time", {31'd0, (tot >= RC + SC + 1) && (tot <= RC + SC + 3)}, 32'd1);
    check("run_ready", {31'd0, mode_req_ready}, 32'd1);
    check("run_busy", {31'd0, busy}, 32'd0);
    check("run_cur_mode", {30'd0, cur_mode}, 32'd0);
    check("run_sel", {14'd0, idsel, fbdsel, odsel}, {14'd0, M0});

    // single-cycle request for mode 2
    request(2'd2);
    pop_entry("req_m2");
    measure("m2_rst", 0, 1'b1, 200, n);
    check("m2_rst_width", n, RC);
    measure("m2_run", 1, 1'b0, 3000, n);
    check("m2_cur_mode", {30'd0, cur_mode}, 32'd2);

    // one-cycle lock drop in RUN keeps the mode
    pll_lock = 1'b0;
    sb.push_back('{mode: 2'd2, sel: M2});
    @(negedge clkin);
    pll_lock = 1'b1;
    n = 1;
    while (out_rst_n && n < 10) begin
      @(negedge clkin);
      n++;
    end
    check("lockloss_latency", {31'd0, n <= 3}, 32'd1);
    pop_entry("lockloss");
    measure("lockloss_run", 1, 1'b0, 3000, n);

    // lock loss and request on the same RUN cycle: request wins
    pll_lock = 1'b0;
    repeat (2) @(negedge clkin);
    request(2'd0);
    pll_lock = 1'b1;
    pop_entry("loss_and_req");
    measure("m0_run", 1, 1'b0, 3000, n);

    // request held while busy is ignored until the first RUN cycle
    request(2'd1);
    pop_entry("req_m1");
    measure("m1_rst", 0, 1'b1, 200, n);
    repeat (3) @(negedge clkin);
    mode_req_valid = 1'b1;
    mode_req       = 2'd3;
    for (int i = 0; i < 5; i++) begin
      check("held_ready", {31'd0, mode_req_ready}, 32'd0);
      check("held_sel", {14'd0, idsel, fbdsel, odsel}, {14'd0, M1});
      @(negedge clkin);
    end
    measure("held_wait", 3, 1'b0, 3000, n);
    check("held_run_out_rst_n", {31'd0, out_rst_n}, 32'd1);
    check("held_run_sel", {14'd0, idsel, fbdsel, odsel}, {14'd0, M1});
    sb.push_back('{mode: 2'd3, sel: M3});
    @(negedge clkin);
    mode_req_valid = 1'b0;
    pop_entry("held_accept");

    // asynchronous reset while in mode 3 WAIT_LOCK
    pll_lock = 1'b0;
    measure("m3_rst", 0, 1'b1, 200, n);
    repeat (5) @(negedge clkin);
    check("m3_wait_pll_reset", {31'd0, pll_reset}, 32'd0);
    check("m3_wait_cur_mode", {30'd0, cur_mode}, 32'd3);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    @(negedge clkin);
    rst_n = 1'b1;

    // no lock: MR attempts, then FAIL
    for (int a = 0; a < MR; a++) begin
      check("attempt_fail_low", {31'd0, fail}, 32'd0);
      measure("attempt_hi", 0, 1'b1, 200, n);
      check("attempt_hi_width", n, RC);
      measure("attempt_lo", 0, 1'b0, 400, n);
      check("attempt_lo_width", n, LT + 1);
    end
    check("fail_flag", {31'd0, fail}, 32'd1);
    check("fail_pll_reset", {31'd0, pll_reset}, 32'd1);
    check("fail_out_rst_n", {31'd0, out_rst_n}, 32'd0);
    check("fail_ready", {31'd0, mode_req_ready}, 32'd1);
    check("fail_busy", {31'd0, busy}, 32'd0);
    repeat (200) @(negedge clkin);
    check("fail_stuck", {30'd0, fail, pll_reset}, 32'd3);

    // recovery from FAIL
    pll_lock = 1'b1;
    repeat (3) @(negedge clkin);
    request(2'd1);
    pop_entry("fail_recover");
    measure("recover_run", 1, 1'b0, 3000, n);
    check("recover_cur_mode", {30'd0, cur_mode}, 32'd1);
    check("recover_sel", {14'd0, idsel, fbdsel, odsel}, {14'd0, M1});
    check("recover_fail", {31'd0, fail}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
